// File: rtl/demux_sched.sv
`default_nettype none
// ============================================================================
// Module   : demux_sched
// Purpose  : Round-robin scheduler for a 1-to-4 demux datapath. Accepts one
//            word at a time from a valid/ready source, grants it to the next
//            eligible channel (ready and not masked), and holds the transfer
//            until that channel acks it or a timeout aborts it. A timed-out
//            channel is masked until mask_clr is pulsed.
// Ports    : clk, rst_n          - clock, async active-low reset
//            in_valid/in_data/in_ready - upstream handshake
//            ch_ready[3:0]       - per-channel ready-to-receive
//            ch_ack[3:0]         - per-channel acceptance pulse
//            mask_clr            - clear all mask bits
//            ch_valid[3:0]       - one-hot strobe to the granted channel
//            ch_data[DW-1:0]     - registered word to the channels
//            sel[1:0]            - demux select (granted index)
//            mask[3:0]           - channels disabled by timeout
//            err                 - one-cycle pulse after a timeout abort
//            busy                - high while a transfer is in flight
// Revision : 1.0 - initial release
// ============================================================================
module demux_sched #(
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic [3:0]    ch_ready,
  input  logic [3:0]    ch_ack,
  input  logic          mask_clr,
  output logic [3:0]    ch_valid,
  output logic [DW-1:0] ch_data,
  output logic [1:0]    sel,
  output logic [3:0]    mask,
  output logic          err,
  output logic          busy
);

  localparam int            TW     = $clog2(TIMEOUT + 1);
  // Timer value on the last permitted SEND cycle (timer is 0 on the first).
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    sel_q, sel_d;
  logic [3:0]    ch_valid_q, ch_valid_d;
  logic [DW-1:0] ch_data_q, ch_data_d;
  logic [3:0]    mask_q, mask_d;
  logic          err_q, err_d;
  logic [TW-1:0] timer_q, timer_d;

  logic [3:0]    eligible;
  logic [1:0]    idx;
  logic [1:0]    off;
  logic [1:0]    grant;

  always_comb begin
    eligible = ch_ready & ~mask_q;

    // Distance from ptr to the first eligible channel; scanning downwards
    // leaves the smallest distance in off.
    idx = '0;
    off = '0;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr_q + 2'(i);
      if (eligible[idx]) begin
        off = 2'(i);
      end
    end
    grant = ptr_q + off;

    in_ready = (state_q == IDLE) && (|eligible);

    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    ch_valid_d = ch_valid_q;
    ch_data_d  = ch_data_q;
    timer_d    = timer_q;
    err_d      = 1'b0;
    // Clear is applied first so a same-cycle timeout still sets its bit.
    mask_d     = mask_clr ? 4'b0000 : mask_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          ch_data_d  = in_data;
          sel_d      = grant;
          ch_valid_d = 4'b0001 << grant;
          timer_d    = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        timer_d = timer_q + 1'b1;
        // Ack has priority over a timeout landing in the same cycle.
        if (ch_ack[sel_q]) begin
          ch_valid_d = 4'b0000;
          ptr_d      = sel_q + 2'd1;
          state_d    = IDLE;
        end else if (timer_q == T_LAST) begin
          ch_valid_d = 4'b0000;
          mask_d     = mask_d | (4'b0001 << sel_q);
          err_d      = 1'b1;
          ptr_d      = sel_q + 2'd1;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      sel_q      <= '0;
      ch_valid_q <= '0;
      ch_data_q  <= '0;
      mask_q     <= '0;
      err_q      <= 1'b0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      ch_valid_q <= ch_valid_d;
      ch_data_q  <= ch_data_d;
      mask_q     <= mask_d;
      err_q      <= err_d;
      timer_q    <= timer_d;
    end
  end

  assign ch_valid = ch_valid_q;
  assign ch_data  = ch_data_q;
  assign sel      = sel_q;
  assign mask     = mask_q;
  assign err      = err_q;
  assign busy     = (state_q == SEND);

endmodule
`default_nettype wire

// File: tb/tb_demux_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_sched
// Purpose  : Self-checking bench for demux_sched. A driver issues directed
//            and random transfers and pushes the predicted outcome of each
//            into a scoreboard queue; a monitor pops and compares whenever
//            the DUT starts and finishes a transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_sched;

  localparam int DW      = 8;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic [3:0]    ch_ready = '0;
  logic [3:0]    ch_ack = '0;
  logic          mask_clr = 1'b0;
  logic [3:0]    ch_valid;
  logic [DW-1:0] ch_data;
  logic [1:0]    sel;
  logic [3:0]    mask;
  logic          err;
  logic          busy;

  demux_sched #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .ch_ready (ch_ready),
    .ch_ack   (ch_ack),
    .mask_clr (mask_clr),
    .ch_valid (ch_valid),
    .ch_data  (ch_data),
    .sel      (sel),
    .mask     (mask),
    .err      (err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    g;
    logic [DW-1:0] data;
    logic [7:0]    len;
    logic          tmo;
    logic [3:0]    mask_after;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  // Reference model state
  int       ptr_m  = 0;
  bit [3:0] mask_m = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // First channel at or after ptr (mod 4) that is ready and not masked.
  function automatic int pick(input int p, input bit [3:0] elig);
    for (int i = 0; i < 4; i++) begin
      if (elig[(p + i) % 4]) return (p + i) % 4;
    end
    return -1;
  endfunction

  // Offer one word. d < TIMEOUT: ack in SEND cycle d+1; otherwise never ack.
  // clr pulses mask_clr on the final SEND cycle.
  task automatic issue(input logic [DW-1:0] data, input bit [3:0] rdy,
                       input int d, input bit clr);
    bit [3:0] elig;
    int       g;
    exp_t     e;
    bit       tmo;
    int       len;
    bit [3:0] stray;
    elig = rdy & ~mask_m;
    ch_ack = '0;
    in_valid = 1'b1;
    in_data = data;
    ch_ready = rdy;
    if (elig == 4'b0000) begin
      #1 chk("in_ready_blocked", in_ready, 0);
      tick();
      chk("idle_no_busy", busy, 0);
      in_valid = 1'b0;
      return;
    end
    g   = pick(ptr_m, elig);
    tmo = (d >= TIMEOUT);
    len = tmo ? TIMEOUT : d + 1;
    e.g    = 2'(g);
    e.data = data;
    e.len  = 8'(len);
    e.tmo  = tmo;
    if (tmo) e.mask_after = clr ? (4'b0001 << g) : (mask_m | (4'b0001 << g));
    else     e.mask_after = clr ? 4'b0000 : mask_m;
    sb_q.push_back(e);
    #1 chk("in_ready_open", in_ready, 1);
    tick();
    in_valid = 1'b0;
    in_data = 8'($urandom);
    for (int k = 1; k <= len; k++) begin
      ch_ready = 4'($urandom);
      stray = 4'($urandom) & ~(4'b0001 << g);
      ch_ack = (!tmo && k == len) ? (stray | (4'b0001 << g)) : stray;
      mask_clr = clr && (k == len);
      tick();
    end
    ch_ack = '0;
    mask_clr = 1'b0;
    ptr_m  = (g + 1) % 4;
    mask_m = e.mask_after;
  endtask

  task automatic idle_cycle(input bit clr);
    in_valid = 1'b0;
    ch_ready = 4'($urandom);
    ch_ack   = 4'($urandom);  // acks in IDLE must be ignored
    mask_clr = clr;
    tick();
    ch_ack = '0;
    mask_clr = 1'b0;
    if (clr) begin
      mask_m = '0;
      chk("mask_after_clr", mask, 0);
    end
  endtask

  // Monitor: checks each transfer as the DUT presents it.
  exp_t cur;
  bit   active = 1'b0;
  int   cnt = 0;

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      chk("busy_vs_valid", busy, (ch_valid != 4'b0000));
      if (ch_valid != 4'b0000 && !active) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_xfer", ch_valid, 0);
        end else begin
          cur = sb_q.pop_front();
          active = 1'b1;
          cnt = 1;
          chk("ch_valid_onehot", ch_valid, 4'b0001 << cur.g);
          chk("sel", sel, cur.g);
          chk("ch_data", ch_data, cur.data);
        end
      end else if (ch_valid != 4'b0000 && active) begin
        cnt++;
        chk("held_stable", {ch_valid, sel, ch_data},
            {4'b0001 << cur.g, cur.g, cur.data});
      end else if (active) begin
        active = 1'b0;
        chk("send_len", cnt, cur.len);
        chk("err_pulse", err, cur.tmo);
        chk("mask_after", mask, cur.mask_after);
      end else begin
        chk("err_quiet", err, 0);
      end
    end
  end

  initial begin
    // Power-on reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ch_valid", ch_valid, 0);
    chk("rst_sel", sel, 0);
    chk("rst_ch_data", ch_data, 0);
    chk("rst_mask", mask, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    tick();

    // Mid-transfer async reset: outputs clear without a clock edge
    ch_ready = 4'b0100;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", ch_valid, 4'b0100);
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_ch_valid", ch_valid, 0);
    chk("async_sel", sel, 0);
    chk("async_mask", mask, 0);
    chk("async_busy", busy, 0);
    chk("async_data", ch_data, 0);
    tick();
    chk("async_err", err, 0);
    rst_n = 1'b1;
    ptr_m = 0;
    mask_m = '0;
    tick();
    mon_en = 1'b1;

    // Round robin over all ready channels, wrapping to ch0
    issue(8'hA1, 4'hF, 1, 0);
    issue(8'hA2, 4'hF, 1, 0);
    issue(8'hA3, 4'hF, 1, 0);
    issue(8'hA4, 4'hF, 1, 0);
    issue(8'hA5, 4'hF, 1, 0);
    // ptr=1: skip non-ready channels to ch3, then ch0
    issue(8'hB1, 4'b1001, 0, 0);
    issue(8'hB2, 4'b1001, 0, 0);
    // ptr=1: timeout on ch2 via ready mask
    issue(8'hC1, 4'b0100, TIMEOUT + 2, 0);
    issue(8'hC2, 4'b0100, 0, 0);          // ch2 masked: blocked
    issue(8'hC3, 4'b1100, 2, 0);          // skips ch2
    idle_cycle(1'b1);
    issue(8'hC4, 4'b0100, 0, 0);          // ch2 usable again
    // Ack on the final allowed cycle wins over timeout
    issue(8'hD1, 4'hF, TIMEOUT - 1, 0);
    // Timeout and mask_clr together: mask ends as just the new bit
    issue(8'hD2, 4'b0010, TIMEOUT, 0);
    issue(8'hD3, 4'b0001, TIMEOUT, 1);

    // Backpressure: mask every channel, then release with mask_clr
    idle_cycle(1'b1);
    for (int i = 0; i < 4; i++) issue(8'(8'hE0 + i), 4'hF, TIMEOUT, 0);
    in_valid = 1'b1;
    in_data  = 8'hEE;
    ch_ready = 4'hF;
    for (int i = 0; i < 3; i++) begin
      #1 chk("all_masked_ready", in_ready, 0);
      tick();
    end
    mask_clr = 1'b1;
    tick();
    mask_clr = 1'b0;
    mask_m = '0;
    issue(8'hEE, 4'hF, 1, 0);

    // Random traffic
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) idle_cycle($urandom_range(0, 5) == 0);
      issue(8'($urandom), 4'($urandom), $urandom_range(0, TIMEOUT + 3),
            $urandom_range(0, 7) == 0);
    end

    repeat (3) tick();
    chk("sb_empty", sb_q.size(), 0);
    chk("no_open_xfer", active, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
